// File: rtl/dickson_pump_pkg.sv
// Shared types and sizing helpers for the Dickson charge-pump controller.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: controller state and pump sub-phase encodings, counter widths, pulse counter width.
package dickson_pump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SOFT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PH_P1 = 2'd0,
    PH_D1 = 2'd1,
    PH_P2 = 2'd2,
    PH_D2 = 2'd3
  } subph_t;

  localparam int SS_CYCLES_DEF = 16;
  localparam int TIMEOUT_DEF   = 1024;

  // Bits needed to hold the value n itself.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int SS_CNT_W = $clog2(SS_CYCLES_DEF + 1);
  localparam int TO_CNT_W = $clog2(TIMEOUT_DEF + 1);
  localparam int PCNT_W   = 16;

endpackage

// File: rtl/dickson_pump_ctrl_phase_gen.sv
// Non-overlapping two-phase pump clock sequencer (P1 -> D1 -> P2 -> D2).
// Latency: phi1 rises the cycle after a start edge; cycle_done is combinational in the last D2 cycle.
// Backpressure: none; run is sampled only when idle or at cycle end, abort wins and stops on the next edge.
// Ports: clk, rst (async, high); run (start/continue), slow (double half-period), abort;
//        div/dead config (captured at P1 entry); phi1, phi2 (registered), cycle_done.
module pump_phase_gen
  import dickson_pump_pkg::*;
#(
  parameter int DIV_W  = 8,
  parameter int DEAD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              slow,
  input  logic              abort,
  input  logic [DIV_W-1:0]  div,
  input  logic [DEAD_W-1:0] dead,
  output logic              phi1,
  output logic              phi2,
  output logic              cycle_done
);

  localparam int CW = (DIV_W + 1 > DEAD_W) ? DIV_W + 1 : DEAD_W;

  subph_t            ph;
  logic              active;
  logic [CW-1:0]     cnt;
  logic [DIV_W-1:0]  div_q;
  logic [DEAD_W-1:0] dead_q;
  logic              slow_q;

  // Half-period minus one: div in normal running, 2*div+1 (i.e. 2*(div+1)-1) in soft-start.
  function automatic logic [CW-1:0] half_m1(input logic [DIV_W-1:0] d, input logic s);
    return s ? CW'({d, 1'b1}) : CW'({1'b0, d});
  endfunction

  assign cycle_done = active && (ph == PH_D2) && (cnt == '0);

  // Each phase register is only ever set from a dead-time sub-phase (or idle), so
  // phi1 and phi2 can never be high in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph     <= PH_P1;
      active <= 1'b0;
      cnt    <= '0;
      div_q  <= '0;
      dead_q <= '0;
      slow_q <= 1'b0;
      phi1   <= 1'b0;
      phi2   <= 1'b0;
    end else if (abort) begin
      ph     <= PH_P1;
      active <= 1'b0;
      cnt    <= '0;
      phi1   <= 1'b0;
      phi2   <= 1'b0;
    end else if (!active || cycle_done) begin
      if (run) begin
        // New pump cycle: configuration is frozen here until the next P1 entry.
        ph     <= PH_P1;
        active <= 1'b1;
        div_q  <= div;
        dead_q <= dead;
        slow_q <= slow;
        cnt    <= half_m1(div, slow);
        phi1   <= 1'b1;
        phi2   <= 1'b0;
      end else begin
        active <= 1'b0;
        phi1   <= 1'b0;
        phi2   <= 1'b0;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end else begin
      case (ph)
        PH_P1: begin
          ph   <= PH_D1;
          phi1 <= 1'b0;
          cnt  <= CW'(dead_q);
        end
        PH_D1: begin
          ph   <= PH_P2;
          phi2 <= 1'b1;
          cnt  <= half_m1(div_q, slow_q);
        end
        PH_P2: begin
          ph   <= PH_D2;
          phi2 <= 1'b0;
          cnt  <= CW'(dead_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dickson_pump_ctrl.sv
// Dickson charge-pump controller: soft-start, comparator pulse-skip regulation, timeout fault.
// Latency: phi1 the cycle after en is first sampled high; comparator reaches the FSM after 2 sync flops.
// Backpressure: none; en=0 wins over everything and returns to IDLE on the next edge.
// Ports: clk, rst (async, high); en; div/dead (half-period-1, dead-1); comp_in (async);
//        phi1/phi2 pump phases; busy/regulated/fault status; pulse_cnt completed cycles.
// Optional feature macro: PUMP_PULSE_CNT_EN (saturating 16-bit pulse counter; else pulse_cnt=0).
module dickson_pump_ctrl
  import dickson_pump_pkg::*;
#(
  parameter int DIV_W     = 8,
  parameter int DEAD_W    = 4,
  parameter int SS_CYCLES = SS_CYCLES_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  div,
  input  logic [DEAD_W-1:0] dead,
  input  logic              comp_in,
  output logic              phi1,
  output logic              phi2,
  output logic              busy,
  output logic              regulated,
  output logic              fault,
  output logic [PCNT_W-1:0] pulse_cnt
);

  localparam int SS_W = cnt_w(SS_CYCLES);
  localparam int TO_W = cnt_w(TIMEOUT);

  state_t          state;
  state_t          state_nx;
  logic            comp_m;
  logic            comp_s;
  logic            comp_seen;
  logic [SS_W-1:0] ss_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            cycle_done;
  logic            ss_last;
  logic            timeout_hit;
  logic            run;
  logic            slow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comp_m <= 1'b0;
      comp_s <= 1'b0;
    end else begin
      comp_m <= comp_in;
      comp_s <= comp_m;
    end
  end

  // Both only meaningful together with cycle_done.
  assign ss_last     = (ss_cnt == SS_W'(SS_CYCLES - 1));
  assign timeout_hit = !comp_seen && !comp_s && (to_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    if (!en) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nx = ST_SOFT;
        ST_SOFT: begin
          // Comparator is ignored for HOLD until the soft-start has fully run.
          if (cycle_done) begin
            if (ss_last && comp_s) state_nx = ST_HOLD;
            else if (timeout_hit)  state_nx = ST_FAULT;
            else if (ss_last)      state_nx = ST_RUN;
          end
        end
        ST_RUN: begin
          if (cycle_done) begin
            if (comp_s)           state_nx = ST_HOLD;
            else if (timeout_hit) state_nx = ST_FAULT;
          end
        end
        ST_HOLD:  if (!comp_s) state_nx = ST_RUN;
        ST_FAULT: ;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Timeout counts completed cycles until the comparator is first seen high, then is disabled
  // until the next return to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_cnt    <= '0;
      to_cnt    <= '0;
      comp_seen <= 1'b0;
    end else if (state_nx == ST_IDLE) begin
      ss_cnt    <= '0;
      to_cnt    <= '0;
      comp_seen <= 1'b0;
    end else begin
      if (state != ST_IDLE && comp_s) comp_seen <= 1'b1;
      if (comp_s || comp_seen)        to_cnt <= '0;
      else if (cycle_done)            to_cnt <= to_cnt + TO_W'(1);
      if (cycle_done && state == ST_SOFT) ss_cnt <= ss_cnt + SS_W'(1);
    end
  end

  // The sequencer only looks at run when idle or at cycle end, so this also
  // covers "start", "keep pumping" and "stop after this cycle".
  assign run  = (state_nx == ST_SOFT) || (state_nx == ST_RUN);
  assign slow = (state_nx == ST_SOFT);

  pump_phase_gen #(
    .DIV_W  (DIV_W),
    .DEAD_W (DEAD_W)
  ) u_phase_gen (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .slow       (slow),
    .abort      (!en),
    .div        (div),
    .dead       (dead),
    .phi1       (phi1),
    .phi2       (phi2),
    .cycle_done (cycle_done)
  );

  assign busy      = (state != ST_IDLE);
  assign regulated = (state == ST_HOLD);
  assign fault     = (state == ST_FAULT);

`ifdef PUMP_PULSE_CNT_EN
  logic [PCNT_W-1:0] pcnt_q;

  // Counts every finished D2, even one that coincides with en dropping; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  pcnt_q <= '0;
    else if (cycle_done && (pcnt_q != '1))    pcnt_q <= pcnt_q + PCNT_W'(1);
  end

  assign pulse_cnt = pcnt_q;
`else
  assign pulse_cnt = '0;
`endif

endmodule

// File: doc/dickson_pump_ctrl.md
Name: dickson_pump_ctrl

Overview:
- Sequencing controller for the on-chip Dickson charge pump on the analog pins.
- Generates two non-overlapping pump clocks, phi1 and phi2, from clk, with a programmable half-period and dead time.
- Runs a soft-start, then regulates by pulse skipping from an external comparator.
- Latches a fault if regulation is not reached within a timeout.
- Sits between the TT digital I/O (config/status) and the pump phase drivers.

Parameters:
- DIV_W, 8: width of the half-period config.
- DEAD_W, 4: width of the dead-time config.
- SS_CYCLES, 16: number of soft-start pump cycles.
- TIMEOUT, 1024: pump cycles allowed without comparator assertion before fault. Minimum is SS_CYCLES+1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  pump enable, level
- div  in  DIV_W  half-period minus 1, in clk cycles
- dead  in  DEAD_W  dead time minus 1, in clk cycles
- comp_in  in  1  asynchronous comparator; 1 means pump output is at or above target
- phi1  out  1  pump phase 1, registered
- phi2  out  1  pump phase 2, registered
- busy  out  1  state is not IDLE
- regulated  out  1  state is HOLD
- fault  out  1  state is FAULT
- pulse_cnt  out  16  completed pump cycles (optional feature)

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, counters 0, synchroniser flops 0.
- comp_in passes through a 2-flop synchroniser to give comp_s.
- States: IDLE, SOFT, RUN, HOLD, FAULT.
- Sub-phases within SOFT and RUN: P1 (phi1=1), D1 (both 0), P2 (phi2=1), D2 (both 0).
- Sub-phase lengths:
  - P1 and P2: H cycles. H = div+1 in RUN; H = 2*(div+1) in SOFT (counter width DIV_W+1).
  - D1 and D2: dead+1 cycles.
- div and dead are captured on every entry to P1 and held for the whole pump cycle.
- Non-overlap invariant: phi1 and phi2 are never both 1 in any cycle, including at transitions.
- IDLE→SOFT: on the first clock edge that samples en=1. P1 starts on that same edge (phi1=1 in the following cycle).
- Pump-cycle end = last cycle of D2. At each end:
  - Increment the cycle count.
  - SOFT→RUN after SS_CYCLES completed cycles.
  - From RUN, or from SOFT once done: if comp_s=1 go to HOLD, otherwise re-enter P1.
- HOLD: both phases 0. When comp_s=0, go to RUN P1 on the next edge.
- Comparator state during SOFT is ignored for HOLD entry but does clear the timeout.
- Timeout:
  - Counts completed pump cycles since leaving IDLE; it is cleared and stops for good once comp_s is first seen at 1.
  - Reaching TIMEOUT → FAULT: phases 0, fault=1.
  - FAULT exits only when en=0 (→IDLE).
- en=0 in any state: next edge → IDLE, both phases 0 immediately (mid-phase truncation allowed). All counters clear; pulse_cnt keeps its value.
- Simultaneous timeout and comp_s=1 at the same end-of-cycle: comp_s wins, go to HOLD with no fault.
- Simultaneous en=0 and any other event: en=0 wins.
- Config changes mid-cycle take effect only at the next P1 entry.
- div=0, dead=0 is legal: RUN period is 4 cycles.

Optional Feature:
- Macro: PUMP_PULSE_CNT_EN.
- Defined: pulse_cnt is a 16-bit counter incremented at each completed D2 (SOFT or RUN). It saturates at 0xFFFF and clears only on rst.
- Undefined: pulse_cnt is tied to 0 and no counter flops are built.

Decomposition:
- Package dickson_pump_pkg:
  - state enum (IDLE, SOFT, RUN, HOLD, FAULT)
  - sub-phase enum (P1, D1, P2, D2)
  - SS_CNT_W and TO_CNT_W as $clog2-derived constants
  - pulse counter width 16
- Sub-module pump_phase_gen:
  - Owns the P1/D1/P2/D2 sequencer, config capture and phase registers.
  - Takes run, slow and abort inputs.
  - Emits phi1, phi2 and cycle_done.
- The top level holds the FSM, synchroniser, timeout and pulse counter.

Test Plan:
- Nominal timing. Set en=1, div=2, dead=0, comp_in=0, SS_CYCLES=2.
  - Soft-start: phi1 high 6, low 1, phi2 high 6, low 1, repeated twice.
  - Then RUN: period 8 (3/1/3/1).
  - phi1&phi2 never both 1.
- Regulation. In RUN, raise comp_in mid-P2.
  - Current cycle completes.
  - regulated=1 and phases 0 from the cycle-end edge.
  - Drop comp_in: phi1 rises 3 edges later (2 sync + 1).
- Timeout fault. Set TIMEOUT=20, comp_in stuck 0.
  - fault=1 after the 20th completed cycle, phases 0.
  - en=0 → IDLE, fault=0.
  - en=1 restarts SOFT.
- Abort mid-operation. Drop en during P1 of RUN.
  - Next cycle phi1=0, busy=0.
  - Assert rst during P2: phi2=0 immediately, asynchronously.
- Config capture. Change div 2→5 in the middle of P1.
  - Current P1 lasts 3 cycles; the next P1 lasts 6.
- Optional counter (with PUMP_PULSE_CNT_EN): after 10 full cycles pulse_cnt=10. Force a preset near the top and check it holds at 0xFFFF.
